// File: rtl/risc_pkg.sv
// Shared decode constants for the ID stage: opcodes, the NOP encoding,
// the LM/SM sequencer state encoding and a helper that assembles a
// single LW/SW micro-op from its fields.
package risc_pkg;

   localparam logic [3:0]  OP_LW  = 4'h4;
   localparam logic [3:0]  OP_SW  = 4'h5;
   localparam logic [3:0]  OP_LM  = 4'h6;
   localparam logic [3:0]  OP_SM  = 4'h7;
   localparam logic [15:0] NOP_IR = 16'hE000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } state_e;

   // LM expands to LW, SM to SW: {op, rA=list index, rB=base, 6-bit offset}
   function automatic logic [15:0] mk_uop(input logic       is_lm,
                                          input logic [2:0] ri,
                                          input logic [2:0] base,
                                          input logic [2:0] off);
      return {(is_lm ? OP_LW : OP_SW), ri, base, 3'b000, off};
   endfunction

endpackage

// File: rtl/id_lmsm_seq_if.sv
// Bundle of the IF/ID -> ID/RR decode signals around id_lmsm_seq.
//   master : the side producing IR_IN/decode values and consuming results
//   slave  : the decode sequencer itself
interface id_lmsm_seq_if;
   logic [15:0] IR_IN;
   logic        IR_VALID_IN;
   logic [15:0] PC_2_IN;
   logic [15:0] PC_2xIMM_IN;
   logic [15:0] IMM_SE_IN;
   logic        ID_RR_STALL_IN;
   logic        FLUSH_IN;
   logic [15:0] IR_OUT;
   logic [15:0] PC_2_OUT;
   logic [15:0] PC_2xIMM_OUT;
   logic [15:0] IMM_SE_OUT;
   logic [2:0]  RA_ADD_OUT;
   logic [2:0]  RB_ADD_OUT;
   logic [2:0]  RC_ADD_OUT;
   logic        ID_RR_EN_OUT;
   logic        IF_ID_STALL_OUT;

   modport master (
      output IR_IN, IR_VALID_IN, PC_2_IN, PC_2xIMM_IN, IMM_SE_IN,
             ID_RR_STALL_IN, FLUSH_IN,
      input  IR_OUT, PC_2_OUT, PC_2xIMM_OUT, IMM_SE_OUT, RA_ADD_OUT,
             RB_ADD_OUT, RC_ADD_OUT, ID_RR_EN_OUT, IF_ID_STALL_OUT
   );

   modport slave (
      input  IR_IN, IR_VALID_IN, PC_2_IN, PC_2xIMM_IN, IMM_SE_IN,
             ID_RR_STALL_IN, FLUSH_IN,
      output IR_OUT, PC_2_OUT, PC_2xIMM_OUT, IMM_SE_OUT, RA_ADD_OUT,
             RB_ADD_OUT, RC_ADD_OUT, ID_RR_EN_OUT, IF_ID_STALL_OUT
   );
endinterface

// File: rtl/lsb_pick8.sv
// Lowest-set-bit finder over an 8-bit vector (combinational).
//   vec_i   : input vector
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : at least one bit set
module lsb_pick8 (
   input  logic [7:0] vec_i,
   output logic [2:0] idx_o,
   output logic       found_o
);
   always_comb begin
      idx_o   = 3'd0;
      found_o = 1'b0;
      // Scan high to low so the last hit is the lowest index.
      for (int i = 7; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o   = 3'(i);
            found_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/id_lmsm_seq.sv
// ID-stage decode with LM/SM expansion. Ordinary instructions pass to
// ID/RR with one cycle of latency; LM/SM are split into one LW/SW per
// set bit of the register list, ascending, holding IF/ID while more
// than one micro-op remains.
// Ports:
//   clk, RST           : clock, synchronous active-high reset
//   IR_IN/IR_VALID_IN  : instruction from IF/ID and its valid
//   PC_2_IN, PC_2xIMM_IN, IMM_SE_IN : decode values for IR_IN
//   ID_RR_STALL_IN     : ID/RR not accepting, hold everything
//   FLUSH_IN           : kill in-flight decode
//   IR_OUT..IMM_SE_OUT, RA/RB/RC_ADD_OUT, ID_RR_EN_OUT : registered results
//   IF_ID_STALL_OUT    : sequencer busy, hold IF/ID
module id_lmsm_seq
   import risc_pkg::*;
(
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] IR_IN,
   input  logic        IR_VALID_IN,
   input  logic [15:0] PC_2_IN,
   input  logic [15:0] PC_2xIMM_IN,
   input  logic [15:0] IMM_SE_IN,
   input  logic        ID_RR_STALL_IN,
   input  logic        FLUSH_IN,
   output logic [15:0] IR_OUT,
   output logic [15:0] PC_2_OUT,
   output logic [15:0] PC_2xIMM_OUT,
   output logic [15:0] IMM_SE_OUT,
   output logic [2:0]  RA_ADD_OUT,
   output logic [2:0]  RB_ADD_OUT,
   output logic [2:0]  RC_ADD_OUT,
   output logic        ID_RR_EN_OUT,
   output logic        IF_ID_STALL_OUT
);

   state_e      state_q, state_d;
   logic [7:0]  mask_q, mask_d;     // list bits still to emit
   logic [2:0]  off_q, off_d;       // offset of the next micro-op
   logic [2:0]  base_q, base_d;
   logic        lm_q, lm_d;         // 1: parent was LM, 0: SM
   logic [15:0] ppc2_q, ppc2_d;     // parent PC_2 / PC_2xIMM
   logic [15:0] ppcimm_q, ppcimm_d;

   logic [15:0] ir_q, ir_d;
   logic [15:0] pc2_q, pc2_d;
   logic [15:0] pcimm_q, pcimm_d;
   logic [15:0] imm_q, imm_d;
   logic [2:0]  ra_q, ra_d;
   logic [2:0]  rb_q, rb_d;
   logic [2:0]  rc_q, rc_d;
   logic        en_q, en_d;

   logic        seq_st;
   logic        is_mult;
   logic [7:0]  pick_vec;
   logic [2:0]  pick_idx;
   logic        pick_found;
   logic [7:0]  rem;
   logic [2:0]  u_base;
   logic        u_lm;
   logic [2:0]  u_off;
   logic [15:0] u_pc2;
   logic [15:0] u_pcimm;

   assign seq_st   = (state_q == ST_SEQ);
   assign is_mult  = (IR_IN[15:12] == OP_LM) || (IR_IN[15:12] == OP_SM);
   // In SEQ the list comes from the remaining mask, else from the new IR.
   assign pick_vec = seq_st ? mask_q : IR_IN[7:0];
   assign rem      = pick_vec & ~(8'd1 << pick_idx);

   lsb_pick8 u_pick (
      .vec_i   (pick_vec),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   // Micro-op fields: live inputs on the accept edge, saved copies in SEQ.
   always_comb begin
      u_base  = seq_st ? base_q   : IR_IN[11:9];
      u_lm    = seq_st ? lm_q     : (IR_IN[15:12] == OP_LM);
      u_off   = seq_st ? off_q    : 3'd0;
      u_pc2   = seq_st ? ppc2_q   : PC_2_IN;
      u_pcimm = seq_st ? ppcimm_q : PC_2xIMM_IN;
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      off_d    = off_q;
      base_d   = base_q;
      lm_d     = lm_q;
      ppc2_d   = ppc2_q;
      ppcimm_d = ppcimm_q;
      ir_d     = ir_q;
      pc2_d    = pc2_q;
      pcimm_d  = pcimm_q;
      imm_d    = imm_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rc_d     = rc_q;
      en_d     = en_q;

      if (FLUSH_IN) begin
         state_d = ST_IDLE;
         mask_d  = 8'd0;
         off_d   = 3'd0;
         en_d    = 1'b0;
         ir_d    = NOP_IR;
      end else if (!ID_RR_STALL_IN) begin
         if (!seq_st && !IR_VALID_IN) begin
            en_d = 1'b0;
            ir_d = NOP_IR;
         end else if (!seq_st && !is_mult) begin
            ir_d    = IR_IN;
            ra_d    = IR_IN[11:9];
            rb_d    = IR_IN[8:6];
            rc_d    = IR_IN[5:3];
            pc2_d   = PC_2_IN;
            pcimm_d = PC_2xIMM_IN;
            imm_d   = IMM_SE_IN;
            en_d    = 1'b1;
         end else if (!pick_found) begin
            // LM/SM with an empty list becomes a bubble
            state_d = ST_IDLE;
            en_d    = 1'b0;
            ir_d    = NOP_IR;
         end else begin
            ir_d    = mk_uop(u_lm, pick_idx, u_base, u_off);
            ra_d    = pick_idx;
            rb_d    = u_base;
            rc_d    = 3'd0;
            imm_d   = {13'd0, u_off};
            pc2_d   = u_pc2;
            pcimm_d = u_pcimm;
            en_d    = 1'b1;
            mask_d  = rem;
            if (rem != 8'd0) begin
               state_d = ST_SEQ;
               off_d   = (u_off == 3'd7) ? 3'd7 : u_off + 3'd1;
            end else begin
               state_d = ST_IDLE;
               off_d   = 3'd0;
            end
            if (!seq_st) begin
               base_d   = u_base;
               lm_d     = u_lm;
               ppc2_d   = PC_2_IN;
               ppcimm_d = PC_2xIMM_IN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         mask_q   <= 8'd0;
         off_q    <= 3'd0;
         base_q   <= 3'd0;
         lm_q     <= 1'b0;
         ppc2_q   <= 16'd0;
         ppcimm_q <= 16'd0;
         ir_q     <= NOP_IR;
         pc2_q    <= 16'd0;
         pcimm_q  <= 16'd0;
         imm_q    <= 16'd0;
         ra_q     <= 3'd0;
         rb_q     <= 3'd0;
         rc_q     <= 3'd0;
         en_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         off_q    <= off_d;
         base_q   <= base_d;
         lm_q     <= lm_d;
         ppc2_q   <= ppc2_d;
         ppcimm_q <= ppcimm_d;
         ir_q     <= ir_d;
         pc2_q    <= pc2_d;
         pcimm_q  <= pcimm_d;
         imm_q    <= imm_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rc_q     <= rc_d;
         en_q     <= en_d;
      end
   end

   assign IR_OUT          = ir_q;
   assign PC_2_OUT        = pc2_q;
   assign PC_2xIMM_OUT    = pcimm_q;
   assign IMM_SE_OUT      = imm_q;
   assign RA_ADD_OUT      = ra_q;
   assign RB_ADD_OUT      = rb_q;
   assign RC_ADD_OUT      = rc_q;
   assign ID_RR_EN_OUT    = en_q;
   assign IF_ID_STALL_OUT = seq_st;

endmodule

// File: tb/tb_id_lmsm_seq.sv
// Bench for id_lmsm_seq: a table of per-cycle {inputs, expected outputs}
// records plus a hand-written full-list LM sequence. Expected outputs are
// queued when a cycle is driven and popped/compared after the edge.
module tb_id_lmsm_seq;

   typedef struct packed {
      logic        rst, flush, stall, valid;
      logic [15:0] ir, pc2, pcimm, imm;
   } in_t;

   typedef struct packed {
      logic [15:0] ir, pc2, pcimm, imm;
      logic [2:0]  ra, rb, rc;
      logic        en, st;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   id_lmsm_seq_if bus ();

   always #5 clk = ~clk;

   id_lmsm_seq dut (
      .clk             (clk),
      .RST             (rst),
      .IR_IN           (bus.IR_IN),
      .IR_VALID_IN     (bus.IR_VALID_IN),
      .PC_2_IN         (bus.PC_2_IN),
      .PC_2xIMM_IN     (bus.PC_2xIMM_IN),
      .IMM_SE_IN       (bus.IMM_SE_IN),
      .ID_RR_STALL_IN  (bus.ID_RR_STALL_IN),
      .FLUSH_IN        (bus.FLUSH_IN),
      .IR_OUT          (bus.IR_OUT),
      .PC_2_OUT        (bus.PC_2_OUT),
      .PC_2xIMM_OUT    (bus.PC_2xIMM_OUT),
      .IMM_SE_OUT      (bus.IMM_SE_OUT),
      .RA_ADD_OUT      (bus.RA_ADD_OUT),
      .RB_ADD_OUT      (bus.RB_ADD_OUT),
      .RC_ADD_OUT      (bus.RC_ADD_OUT),
      .ID_RR_EN_OUT    (bus.ID_RR_EN_OUT),
      .IF_ID_STALL_OUT (bus.IF_ID_STALL_OUT)
   );

   int   ntests = 0;
   int   nfail  = 0;
   out_t exp_q[$];
   vec_t vecs[18];

   function automatic in_t mi(input logic r, f, s, v,
                              input logic [15:0] ir, pc2, pcimm, imm);
      in_t x;
      x.rst = r; x.flush = f; x.stall = s; x.valid = v;
      x.ir = ir; x.pc2 = pc2; x.pcimm = pcimm; x.imm = imm;
      return x;
   endfunction

   function automatic out_t mo(input logic [15:0] ir, pc2, pcimm, imm,
                               input logic [2:0] ra, rb, rc,
                               input logic en, st);
      out_t x;
      x.ir = ir; x.pc2 = pc2; x.pcimm = pcimm; x.imm = imm;
      x.ra = ra; x.rb = rb; x.rc = rc; x.en = en; x.st = st;
      return x;
   endfunction

   task automatic step(input string nm, input in_t si, input out_t so);
      out_t got, e;
      rst                = si.rst;
      bus.FLUSH_IN       = si.flush;
      bus.ID_RR_STALL_IN = si.stall;
      bus.IR_VALID_IN    = si.valid;
      bus.IR_IN          = si.ir;
      bus.PC_2_IN        = si.pc2;
      bus.PC_2xIMM_IN    = si.pcimm;
      bus.IMM_SE_IN      = si.imm;
      exp_q.push_back(so);
      @(posedge clk);
      #1;
      got = mo(bus.IR_OUT, bus.PC_2_OUT, bus.PC_2xIMM_OUT, bus.IMM_SE_OUT,
               bus.RA_ADD_OUT, bus.RB_ADD_OUT, bus.RC_ADD_OUT,
               bus.ID_RR_EN_OUT, bus.IF_ID_STALL_OUT);
      e = exp_q.pop_front();
      ntests++;
      if (got !== e) begin
         nfail++;
         $display("FAIL %s: got ir=%h pc2=%h pcimm=%h imm=%h ra=%0d rb=%0d rc=%0d en=%b st=%b, exp ir=%h pc2=%h pcimm=%h imm=%h ra=%0d rb=%0d rc=%0d en=%b st=%b",
                  nm, got.ir, got.pc2, got.pcimm, got.imm, got.ra, got.rb, got.rc, got.en, got.st,
                  e.ir, e.pc2, e.pcimm, e.imm, e.ra, e.rb, e.rc, e.en, e.st);
      end
   endtask

   initial begin
      // reset
      vecs[0]  = '{mi(1,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'hE000,16'h0000,16'h0000,16'h0000,0,0,0,0,0)};
      // plain pass-through, then idle bubble holding other fields
      vecs[1]  = '{mi(0,0,0,1,16'h1298,16'h0010,16'h0020,16'h0005), mo(16'h1298,16'h0010,16'h0020,16'h0005,1,2,3,1,0)};
      vecs[2]  = '{mi(0,0,0,0,16'h1298,16'h0011,16'h0021,16'h0006), mo(16'hE000,16'h0010,16'h0020,16'h0005,1,2,3,0,0)};
      // LM 64A5: base 2, list bits 0,2,5,7; IR_IN ignored in SEQ; stall x2
      vecs[3]  = '{mi(0,0,0,1,16'h64A5,16'h0100,16'h0200,16'hFFA5), mo(16'h4080,16'h0100,16'h0200,16'h0000,0,2,0,1,1)};
      vecs[4]  = '{mi(0,0,0,1,16'h1298,16'h0999,16'h0888,16'h0777), mo(16'h4481,16'h0100,16'h0200,16'h0001,2,2,0,1,1)};
      vecs[5]  = '{mi(0,0,1,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'h4481,16'h0100,16'h0200,16'h0001,2,2,0,1,1)};
      vecs[6]  = '{mi(0,0,1,1,16'h1298,16'h0000,16'h0000,16'h0000), mo(16'h4481,16'h0100,16'h0200,16'h0001,2,2,0,1,1)};
      vecs[7]  = '{mi(0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'h4A82,16'h0100,16'h0200,16'h0002,5,2,0,1,1)};
      vecs[8]  = '{mi(0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'h4E83,16'h0100,16'h0200,16'h0003,7,2,0,1,0)};
      // SM with empty list: bubble, next instruction accepted next edge
      vecs[9]  = '{mi(0,0,0,1,16'h7000,16'h0300,16'h0301,16'h0302), mo(16'hE000,16'h0100,16'h0200,16'h0003,7,2,0,0,0)};
      vecs[10] = '{mi(0,0,0,1,16'h5A3C,16'h0400,16'h0500,16'h003C), mo(16'h5A3C,16'h0400,16'h0500,16'h003C,5,0,7,1,0)};
      // SM 7E03 (base 7, bits 0,1), then flush together with stall
      vecs[11] = '{mi(0,0,0,1,16'h7E03,16'h0600,16'h0700,16'h0000), mo(16'h51C0,16'h0600,16'h0700,16'h0000,0,7,0,1,1)};
      vecs[12] = '{mi(0,1,1,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'hE000,16'h0600,16'h0700,16'h0000,0,7,0,0,0)};
      vecs[13] = '{mi(0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'hE000,16'h0600,16'h0700,16'h0000,0,7,0,0,0)};
      // reset during the second micro-op of 64A5
      vecs[14] = '{mi(0,0,0,1,16'h64A5,16'h0800,16'h0900,16'h0000), mo(16'h4080,16'h0800,16'h0900,16'h0000,0,2,0,1,1)};
      vecs[15] = '{mi(1,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'hE000,16'h0000,16'h0000,16'h0000,0,0,0,0,0)};
      vecs[16] = '{mi(0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000), mo(16'hE000,16'h0000,16'h0000,16'h0000,0,0,0,0,0)};
      // single-bit list (bit 7): one micro-op, never enters SEQ
      vecs[17] = '{mi(0,0,0,1,16'h6C80,16'h0A00,16'h0B00,16'h0000), mo(16'h4F80,16'h0A00,16'h0B00,16'h0000,7,6,0,1,0)};

      for (int k = 0; k < 18; k++)
         step($sformatf("vec%0d", k), vecs[k].i, vecs[k].o);

      // full list LM 61FF (base 0): eight micro-ops, offsets 0..7
      step("full0", mi(0,0,0,1,16'h61FF,16'h0C00,16'h0D00,16'h1234),
           mo(16'h4000,16'h0C00,16'h0D00,16'h0000,0,0,0,1,1));
      for (int n = 1; n < 8; n++) begin
         logic [15:0] eir;
         eir = 16'h4000 | (16'(n) << 9) | 16'(n);
         step($sformatf("full%0d", n), mi(0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000),
              mo(eir,16'h0C00,16'h0D00,16'(n),3'(n),0,0,1,(n < 7)));
      end
      step("full_done", mi(0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000),
           mo(16'hE000,16'h0C00,16'h0D00,16'h0007,7,0,0,0,0));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
